// File: rtl/expipe_pkg.sv
// Shared execution-pipeline types: ROB index and register-status counter width.
package expipe_pkg;
  localparam int ROB_IDX_W     = 5;
  localparam int REGSTAT_CNT_W = 2;
  typedef logic [ROB_IDX_W-1:0] rob_idx_t;
endpackage

// File: rtl/regstat_entry.sv
// One architectural register: saturating multi-step writer counter plus newest-writer ROB index.
module regstat_entry
  import expipe_pkg::*;
#(
  parameter int SUM_W = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic [SUM_W-1:0]         inc_i,
  input  logic [SUM_W-1:0]         dec_i,
  input  logic                     rob_we_i,
  input  rob_idx_t                 rob_i,
  output logic [REGSTAT_CNT_W-1:0] cnt_o,
  output rob_idx_t                 rob_o
);
  localparam logic [SUM_W-1:0] CntMax = SUM_W'((1 << REGSTAT_CNT_W) - 1);

  logic [REGSTAT_CNT_W-1:0] cnt_d, cnt_q;
  rob_idx_t                 rob_d, rob_q;
  logic [SUM_W-1:0]         up;

  // Increments are applied before decrements so a same-cycle issue can cover a commit.
  always_comb begin
    up    = SUM_W'(cnt_q) + inc_i;
    cnt_d = cnt_q;
    rob_d = rob_q;
    if (clr_i) begin
      cnt_d = '0;
      rob_d = '0;
    end else begin
      if (up < dec_i)                cnt_d = '0;
      else if (up - dec_i > CntMax)  cnt_d = '1;
      else                           cnt_d = REGSTAT_CNT_W'(up - dec_i);
      if (rob_we_i) rob_d = rob_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      rob_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      rob_q <= rob_d;
    end
  end

  assign cnt_o = cnt_q;
  assign rob_o = rob_q;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!rst_i && !clr_i) begin
      assert (up >= dec_i) else $error("regstat_entry: commit to idle register");
      assert (up < dec_i || (up - dec_i) <= CntMax) else $error("regstat_entry: busy counter overflow");
    end
  end
`endif
endmodule

// File: rtl/regstat_mp.sv
// Multi-port register status table: per-register in-flight writer count and newest ROB index,
// with issue back-pressure, intra-bundle source bypass and multi-commit retirement.
module regstat_mp
  import expipe_pkg::*;
#(
  parameter  int          REG_NUM    = 32,
  parameter  int          ISSUE_W    = 2,
  parameter  int          COMM_W     = 2,
  parameter  int          READ_PORTS = 3,
  parameter  int unsigned ZERO_REG   = 0,
  localparam int          RegIdxLen  = $clog2(REG_NUM)
) (
  input  logic                                               clk_i,
  input  logic                                               rst_i,
  input  logic                                               flush_i,
  input  logic     [ISSUE_W-1:0]                             issue_valid_i,
  output logic                                               issue_ready_o,
  input  logic     [ISSUE_W-1:0][RegIdxLen-1:0]              issue_rd_idx_i,
  input  rob_idx_t [ISSUE_W-1:0]                             issue_rob_idx_i,
  input  logic     [ISSUE_W-1:0][READ_PORTS-1:0][RegIdxLen-1:0] issue_rs_idx_i,
  output logic     [ISSUE_W-1:0][READ_PORTS-1:0]             issue_rs_busy_o,
  output rob_idx_t [ISSUE_W-1:0][READ_PORTS-1:0]             issue_rs_rob_idx_o,
  input  logic     [COMM_W-1:0]                              comm_valid_i,
  input  logic     [COMM_W-1:0][RegIdxLen-1:0]               comm_rd_idx_i
);
  localparam int MaxW = (ISSUE_W > COMM_W) ? ISSUE_W : COMM_W;
  localparam int SumW = REGSTAT_CNT_W + $clog2(MaxW) + 1;
  localparam logic [SumW-1:0] CntMax = SumW'((1 << REGSTAT_CNT_W) - 1);

  logic [REG_NUM-1:0][REGSTAT_CNT_W-1:0] cnt;
  rob_idx_t [REG_NUM-1:0]                rob_tab;
  logic [REG_NUM-1:0][SumW-1:0]          inc, dec;
  logic [REG_NUM-1:0]                    rob_we;
  rob_idx_t [REG_NUM-1:0]                rob_wd;
  logic [ISSUE_W-1:0]                    issue_fire;
  logic [SumW-1:0]                       demand;

  function automatic logic is_zero(input logic [RegIdxLen-1:0] idx);
    return (ZERO_REG != 0) && (idx == '0);
  endfunction

  // Demand counts every valid slot, fired or not: the bundle is all-or-nothing.
  always_comb begin
    issue_ready_o = !flush_i;
    demand        = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      demand = SumW'(cnt[issue_rd_idx_i[k]]);
      for (int j = 0; j < ISSUE_W; j++)
        if (issue_valid_i[j] && issue_rd_idx_i[j] == issue_rd_idx_i[k])
          demand = demand + SumW'(1);
      if (issue_valid_i[k] && !is_zero(issue_rd_idx_i[k]) && demand > CntMax)
        issue_ready_o = 1'b0;
    end
  end

  assign issue_fire = issue_valid_i & {ISSUE_W{issue_ready_o}};

  // Ascending slot order lets the youngest writer own rob_wd.
  always_comb begin
    inc    = '0;
    dec    = '0;
    rob_we = '0;
    rob_wd = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      if (issue_fire[k] && !is_zero(issue_rd_idx_i[k])) begin
        inc[issue_rd_idx_i[k]]    = inc[issue_rd_idx_i[k]] + SumW'(1);
        rob_we[issue_rd_idx_i[k]] = 1'b1;
        rob_wd[issue_rd_idx_i[k]] = issue_rob_idx_i[k];
      end
    end
    for (int j = 0; j < COMM_W; j++)
      if (comm_valid_i[j] && !is_zero(comm_rd_idx_i[j]))
        dec[comm_rd_idx_i[j]] = dec[comm_rd_idx_i[j]] + SumW'(1);
  end

  for (genvar i = 0; i < REG_NUM; i++) begin : g_ent
    regstat_entry #(.SUM_W(SumW)) u_ent (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (flush_i),
      .inc_i    (inc[i]),
      .dec_i    (dec[i]),
      .rob_we_i (rob_we[i]),
      .rob_i    (rob_wd[i]),
      .cnt_o    (cnt[i]),
      .rob_o    (rob_tab[i])
    );
  end

  // Older in-bundle writers override the table; the last matching j is the youngest older one.
  always_comb begin
    issue_rs_busy_o    = '0;
    issue_rs_rob_idx_o = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      for (int p = 0; p < READ_PORTS; p++) begin
        issue_rs_busy_o[k][p]    = cnt[issue_rs_idx_i[k][p]] != '0;
        issue_rs_rob_idx_o[k][p] = issue_rs_busy_o[k][p] ? rob_tab[issue_rs_idx_i[k][p]] : '0;
        for (int j = 0; j < k; j++) begin
          if (issue_valid_i[j] && issue_rd_idx_i[j] == issue_rs_idx_i[k][p]) begin
            issue_rs_busy_o[k][p]    = 1'b1;
            issue_rs_rob_idx_o[k][p] = issue_rob_idx_i[j];
          end
        end
        if (is_zero(issue_rs_idx_i[k][p])) begin
          issue_rs_busy_o[k][p]    = 1'b0;
          issue_rs_rob_idx_o[k][p] = '0;
        end
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!rst_i) assert (!(flush_i && issue_ready_o)) else $error("regstat_mp: ready during flush");
  end
`endif
endmodule

// File: doc/regstat_mp.md
# regstat_mp

Multi-port register status table for the superscalar execution pipeline, successor to the single-issue FP/int status tables. Per architectural register it tracks the number of in-flight writers and the ROB index of the newest one. It serves ISSUE_W issue slots per cycle, each with READ_PORTS source lookups, applying intra-bundle forwarding. It also accepts COMM_W commits per cycle and back-pressures issue before any busy counter can overflow.

## Interface
- REG_NUM, 32: architectural registers; power of 2; RegIdxLen = $clog2(REG_NUM), not overridable.
- ISSUE_W, 2: issue slots per cycle; slot 0 is oldest in program order.
- COMM_W, 2: commit slots per cycle.
- READ_PORTS, 3: source lookups per issue slot.
- ZERO_REG, 0: when 1, register 0 is hardwired and never busy (integer file).
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- flush_i  in  1  pipeline flush; clears all state.
- issue_valid_i  in  [ISSUE_W]  slot k carries an instruction writing a register.
- issue_ready_o  out  1  bundle accepted; all-or-nothing for the whole bundle.
- issue_rd_idx_i  in  [ISSUE_W][RegIdxLen]  destination register per slot.
- issue_rob_idx_i  in  [ISSUE_W] expipe_pkg::rob_idx_t  allocated ROB entry per slot.
- issue_rs_idx_i  in  [ISSUE_W][READ_PORTS][RegIdxLen]  source register indices.
- issue_rs_busy_o  out  [ISSUE_W][READ_PORTS]  source is pending in ROB or execution.
- issue_rs_rob_idx_o  out  [ISSUE_W][READ_PORTS] rob_idx_t  producer ROB entry; 0 when not busy.
- comm_valid_i  in  [COMM_W]  slot j commits a register-writing instruction.
- comm_rd_idx_i  in  [COMM_W][RegIdxLen]  destination register of committing slot.

## Operation
- State per register i: cnt[i] (REGSTAT_CNT_W bits) and rob[i] (rob_idx_t).
- Issue fire: issue_fire[k] = issue_valid_i[k] && issue_ready_o.
- Counter update: cnt[i]_next = cnt[i] + inc_i - dec_i.
  - inc_i = number of fired slots with rd == i.
  - dec_i = number of valid commit slots with rd == i.
  - Compute at REGSTAT_CNT_W+clog2(max(ISSUE_W,COMM_W))+1 bits before truncation.
- rob[i]: takes issue_rob_idx_i of the highest-numbered (youngest) fired slot targeting i; otherwise holds.
- issue_ready_o = !flush_i && no valid slot k where cnt[rd_k] + (valid slots targeting rd_k) > 2^REGSTAT_CNT_W-1.
  - Same-cycle commits are not credited.
  - Deasserts for the whole bundle.
- Lookups read registered state:
  - busy = cnt[rs] != 0
  - rob_idx = busy ? rob[rs] : 0
- Intra-bundle bypass, checked on issue_valid_i, independent of ready: if any slot j < k is valid with rd == rs, slot k's lookup returns busy=1 and rob_idx = issue_rob_idx_i of the largest such j. The bypass takes precedence over table state.
- Same-cycle commits never clear lookup outputs; the ROB forwards the value.
- Commit to a register with cnt 0: counter saturates at 0; simulation assertion fires.
- ZERO_REG=1: issues and commits to index 0 are ignored, index 0 never bypasses, lookups of 0 return busy 0 / rob 0, and index 0 never causes ready to drop.
- Priority: rst_i > flush_i > issue/commit.
  - Flush in the same cycle as a valid bundle: bundle not accepted (ready 0), all cnt/rob cleared.

## Timing
- Lookups, bypass and issue_ready_o are combinational.
  - issue_ready_o depends on issue_valid_i and issue_rd_idx_i; upstream must not derive valid from ready.
- Table updates are visible to lookups the cycle after fire/commit.
- Reset (and flush) take effect at the next edge. Afterwards: all cnt 0, all rob 0; every issue_rs_busy_o 0 and issue_rs_rob_idx_o 0 absent bypass; issue_ready_o 1 absent flush.
- Reset or flush mid-burst discards in-flight state with no residual busy bits.

## Structure
- rob_idx_t and REGSTAT_CNT_W stay in expipe_pkg; no new package types.
- Sub-module regstat_entry: one per register.
  - Inputs: inc/dec counts, rob write enable and value, clear.
  - Outputs: cnt, rob.
  - Implements the saturating multi-step up/down counter.
- Top level holds the decode of issue/commit onto entries, ready logic, and the lookup/bypass mux.
- Assertions under `ifndef SYNTHESIS`:
  - no counter overflow;
  - no commit to a zero counter;
  - issue_ready_o low whenever flush_i is high.

## Test plan
- Reset, then slot0 issues rd=5 rob=3 -> next cycle, lookup rs=5 returns busy 1, rob 3. Commit rd=5 -> following cycle busy 0, rob_idx 0.
- Same bundle: slot0 rd=7 rob=10, slot1 rd=7 rob=11 with slot1 rs=7 -> same cycle, slot1 lookup busy 1 rob 10. Next cycle cnt[7]=2, rob[7]=11.
- Issue rd=4 and commit rd=4 in the same cycle with cnt[4]=1 -> cnt[4] stays 1, rob[4] updated. Lookup that cycle still busy.
- Fill cnt[9] to max-1, then a bundle with both slots rd=9 -> issue_ready_o 0, no state change. Same with one slot -> accepted, counter at max.
- Flush asserted with a valid bundle and cnt[2]=3 -> ready 0 that cycle, all lookups busy 0 next cycle.
- ZERO_REG=1: issue rd=0, then lookup rs=0 -> busy 0, rob 0, ready unaffected.
